// File: rtl/n_point_ifft_seq.sv
// Sequential radix-2 inverse FFT. It captures a frame in bit-reversed order, runs one
// butterfly stage per clock with a 1/2 scale per stage, then holds the result until the consumer accepts it.
module n_point_ifft_seq #(
  parameter int WIDTH   = 32,
  parameter int SAMPLES = 8,
  parameter int TW_FRAC = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SAMPLES-1:0][WIDTH-1:0]    sampleInputs,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SAMPLES-1:0][WIDTH-1:0]    outputs
);

  localparam int  H     = WIDTH / 2;
  localparam int  LOG2N = $clog2(SAMPLES);
  localparam int  SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int  TW_W  = TW_FRAC + 2;
  localparam int  PW    = H + TW_W + 1;
  localparam int  AW    = H + 2;
  localparam real PI    = 3.14159265358979323846;

  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (H - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (H - 1)));
  localparam logic [SW-1:0]        LAST_STAGE = SW'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [SAMPLES-1:0][WIDTH-1:0]  frame_t;
  typedef logic [SAMPLES/2-1:0][TW_W-1:0] tw_tbl_t;

  // Entry k holds e^{+i*2*pi*k/SAMPLES}; stage s, offset j uses k = j*SAMPLES/2^(s+1).
  function automatic tw_tbl_t tw_table(input bit is_sin);
    tw_tbl_t tbl;
    real     ang;
    for (int k = 0; k < SAMPLES / 2; k++) begin
      ang    = 2.0 * PI * $itor(k) / $itor(SAMPLES);
      tbl[k] = TW_W'($rtoi($floor((is_sin ? $sin(ang) : $cos(ang)) * $itor(1 << TW_FRAC) + 0.5)));
    end
    return tbl;
  endfunction

  localparam tw_tbl_t TW_RE = tw_table(1'b0);
  localparam tw_tbl_t TW_IM = tw_table(1'b1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = idx[LOG2N-1-b];
    return r;
  endfunction

  function automatic logic [H-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SMAX)      return SMAX[H-1:0];
    else if (v < SMIN) return SMIN[H-1:0];
    else               return v[H-1:0];
  endfunction

  // Returns {a', b'} with a' = (a+b*W)>>>1 and b' = (a-b*W)>>>1, each half saturated.
  function automatic logic [2*WIDTH-1:0] bfly(input logic [WIDTH-1:0] a, b,
                                              input logic signed [TW_W-1:0] wr, wi);
    logic signed [H-1:0]  ar, ai, br, bi;
    logic signed [PW-1:0] prod_re, prod_im;
    logic signed [AW-1:0] tr, ti, sr, si, dr, di;
    ar      = a[WIDTH-1:H];
    ai      = a[H-1:0];
    br      = b[WIDTH-1:H];
    bi      = b[H-1:0];
    prod_re = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
    prod_im = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
    tr      = AW'(prod_re >>> TW_FRAC);
    ti      = AW'(prod_im >>> TW_FRAC);
    sr      = AW'(ar) + tr;
    si      = AW'(ai) + ti;
    dr      = AW'(ar) - tr;
    di      = AW'(ai) - ti;
    return {sat(sr >>> 1), sat(si >>> 1), sat(dr >>> 1), sat(di >>> 1)};
  endfunction

  state_t          state_q;
  logic [SW-1:0]   stage_q;
  frame_t          work_q, work_d;
  logic            in_ready_q, out_valid_q;

  always_comb begin
    // NOTE: default to the held value first so no path through the case infers a latch.
    work_d = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < SAMPLES; i++) work_d[bitrev(LOG2N'(i))] = sampleInputs[i];
        end
      end
      RUN: begin
        for (int s = 0; s < LOG2N; s++) begin
          if (stage_q == SW'(s)) begin
            for (int g = 0; g < SAMPLES; g += (2 << s)) begin
              for (int j = 0; j < (1 << s); j++) begin
                {work_d[g+j], work_d[g+j+(1<<s)]} =
                  bfly(work_q[g+j], work_q[g+j+(1<<s)],
                       TW_RE[j*(SAMPLES>>(s+1))], TW_IM[j*(SAMPLES>>(s+1))]);
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the working array is reset as well, because an aborted frame must read back as zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values.
      work_q <= work_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= RUN;
            stage_q    <= '0;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (stage_q == LAST_STAGE) begin
            state_q     <= DONE;
            stage_q     <= '0;
            out_valid_q <= 1'b1;
          end else begin
            stage_q <= stage_q + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign outputs   = work_q;

endmodule

// File: tb/tb_n_point_ifft_seq.sv
// Bench for n_point_ifft_seq. It runs 4-point and 8-point instances against a real-valued
// inverse DFT model and also checks hand-computed frames, backpressure and a reset mid-frame.
module tb_n_point_ifft_seq;

  localparam real PI  = 3.14159265358979323846;
  localparam real TOL = 2.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0][31:0] x4, y4;
  logic             in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0][31:0] x8, y8;

  int n_checks = 0;
  int n_fail   = 0;

  real q4_re[$], q4_im[$], q8_re[$], q8_im[$];
  logic [7:0][31:0] mon_frame;

  n_point_ifft_seq #(.WIDTH(32), .SAMPLES(4), .TW_FRAC(14)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .sampleInputs(x4), .out_valid(out_valid4), .out_ready(out_ready4), .outputs(y4));

  n_point_ifft_seq #(.WIDTH(32), .SAMPLES(8), .TW_FRAC(14)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .sampleInputs(x8), .out_valid(out_valid8), .out_ready(out_ready8), .outputs(y8));

  function automatic logic [31:0] cpx(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  function automatic real part(input logic [31:0] w, input bit imag);
    logic signed [15:0] h;
    int v;
    h = imag ? w[15:0] : w[31:16];
    v = h;
    return $itor(v);
  endfunction

  // Reference: x[t] = (1/n) * sum_k X[k] * e^{+i*2*pi*t*k/n}
  function automatic real idft_pt(input int n, input logic [7:0][31:0] x, input int t, input bit imag);
    real acc = 0.0;
    real ang, xr, xi;
    for (int k = 0; k < n; k++) begin
      ang = 2.0 * PI * $itor(t * k) / $itor(n);
      xr  = part(x[k], 1'b0);
      xi  = part(x[k], 1'b1);
      acc += imag ? (xr * $sin(ang) + xi * $cos(ang)) : (xr * $cos(ang) - xi * $sin(ang));
    end
    return acc / $itor(n);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input real act, input real exp);
    n_checks++;
    if (act - exp > TOL || exp - act > TOL) begin
      n_fail++;
      $display("FAIL %s: got %f, expected %f (tol %f)", name, act, exp, TOL);
    end
  endtask

  // Expectation queues: push at accept, pop at output handshake, flush on reset.
  always @(posedge clk) begin
    if (rst) begin
      q4_re.delete(); q4_im.delete(); q8_re.delete(); q8_im.delete();
    end else begin
      if (out_valid4 && out_ready4 && q4_re.size() >= 4)
        repeat (4) begin void'(q4_re.pop_front()); void'(q4_im.pop_front()); end
      if (out_valid8 && out_ready8 && q8_re.size() >= 8)
        repeat (8) begin void'(q8_re.pop_front()); void'(q8_im.pop_front()); end
      if (in_valid4 && in_ready4) begin
        mon_frame = '0;
        mon_frame[3:0] = x4;
        for (int t = 0; t < 4; t++) begin
          q4_re.push_back(idft_pt(4, mon_frame, t, 1'b0));
          q4_im.push_back(idft_pt(4, mon_frame, t, 1'b1));
        end
      end
      if (in_valid8 && in_ready8) begin
        mon_frame = x8;
        for (int t = 0; t < 8; t++) begin
          q8_re.push_back(idft_pt(8, mon_frame, t, 1'b0));
          q8_im.push_back(idft_pt(8, mon_frame, t, 1'b1));
        end
      end
    end
  end

  // Compare process: each cycle the outputs are valid, they must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("excl4", 32'(in_ready4 & out_valid4), 32'd0);
      check("excl8", 32'(in_ready8 & out_valid8), 32'd0);
      if (out_valid4) begin
        if (q4_re.size() < 4) check("exp4_avail", 32'(q4_re.size()), 32'd4);
        else for (int i = 0; i < 4; i++) begin
          check_tol($sformatf("ref4[%0d].re", i), part(y4[i], 1'b0), q4_re[i]);
          check_tol($sformatf("ref4[%0d].im", i), part(y4[i], 1'b1), q4_im[i]);
        end
      end
      if (out_valid8) begin
        if (q8_re.size() < 8) check("exp8_avail", 32'(q8_re.size()), 32'd8);
        else for (int i = 0; i < 8; i++) begin
          check_tol($sformatf("ref8[%0d].re", i), part(y8[i], 1'b0), q8_re[i]);
          check_tol($sformatf("ref8[%0d].im", i), part(y8[i], 1'b1), q8_im[i]);
        end
      end
    end
  end

  task automatic send4(input logic [3:0][31:0] x, output int lat);
    @(negedge clk);
    x4 = x;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid4) check("timeout4", 32'(out_valid4), 32'd1);
  endtask

  task automatic send8(input logic [7:0][31:0] x, output int lat);
    @(negedge clk);
    x8 = x;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid8) check("timeout8", 32'(out_valid8), 32'd1);
  endtask

  task automatic ack4();
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    check("rdy4_after_ack", 32'(in_ready4), 32'd1);
    check("vld4_after_ack", 32'(out_valid4), 32'd0);
  endtask

  task automatic ack8();
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check("rdy8_after_ack", 32'(in_ready8), 32'd1);
    check("vld8_after_ack", 32'(out_valid8), 32'd0);
  endtask

  task automatic expect4(input string name, input logic [3:0][31:0] e);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("%s[%0d]", name, i), y4[i], e[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] xa, ea, xc;
    logic [7:0][31:0] xb;
    int lat;

    in_valid4 = 1'b0; out_ready4 = 1'b0; x4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    #1;
    check("rst_rdy4", 32'(in_ready4), 32'd1);
    check("rst_vld4", 32'(out_valid4), 32'd0);
    check("rst_rdy8", 32'(in_ready8), 32'd1);
    check("rst_vld8", 32'(out_valid8), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_y4[%0d]", i), y4[i], 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_y8[%0d]", i), y8[i], 32'd0);

    // 4-point impulse: every output is 400/4, latency 2
    xa = '0; xa[0] = cpx(400, 0);
    send4(xa, lat);
    check("lat4_impulse", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) ea[i] = cpx(100, 0);
    expect4("imp4", ea);
    ack4();

    // 4-point constant: all energy lands in sample 0
    for (int i = 0; i < 4; i++) xa[i] = cpx(400, 0);
    xc = xa;
    send4(xa, lat);
    ea = '0; ea[0] = cpx(400, 0);
    expect4("const4", ea);
    ack4();

    // 4-point single bin 1: a rotating phasor of amplitude 100
    xa = '0; xa[1] = cpx(400, 0);
    send4(xa, lat);
    ea[0] = cpx(100, 0); ea[1] = cpx(0, 100); ea[2] = cpx(-100, 0); ea[3] = cpx(0, -100);
    expect4("bin4", ea);
    ack4();

    // Backpressure: result held, new frame offered but ignored
    xa = '0; xa[0] = cpx(400, 0);
    send4(xa, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x4 = xc;
      in_valid4 = 1'b1;
      check("bp_rdy4", 32'(in_ready4), 32'd0);
      check("bp_vld4", 32'(out_valid4), 32'd1);
      for (int i = 0; i < 4; i++) check($sformatf("bp_y4[%0d]", i), y4[i], cpx(100, 0));
    end
    in_valid4 = 1'b0;
    ack4();
    for (int i = 0; i < 4; i++) check($sformatf("bp_hold_y4[%0d]", i), y4[i], cpx(100, 0));

    // Reset during stage 1 discards the frame at once
    @(negedge clk);
    x4 = xa;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld4", 32'(out_valid4), 32'd0);
    check("mid_rst_rdy4", 32'(in_ready4), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("mid_rst_y4[%0d]", i), y4[i], 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send4(xa, lat);
    check("lat4_after_rst", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) ea[i] = cpx(100, 0);
    expect4("imp4_after_rst", ea);
    ack4();

    // 8-point impulse: all (100,0), latency 3
    xb = '0; xb[0] = cpx(800, 0);
    send8(xb, lat);
    check("lat8_impulse", 32'(lat), 32'd3);
    @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("imp8[%0d]", i), y8[i], cpx(100, 0));
    ack8();

    // Random 8-point frames, random consumer delay; the compare process checks them
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 8; i++)
        xb[i] = cpx(int'($urandom_range(8000)) - 4000, int'($urandom_range(8000)) - 4000);
      send8(xb, lat);
      check($sformatf("lat8_rand%0d", f), 32'(lat), 32'd3);
      repeat ($urandom_range(3)) @(posedge clk);
      ack8();
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
